// File: rtl/ram_pkg.sv
// Shared widths and FSM state type for ram_burst_master and its bus interface.
package ram_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 64;

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// Client-side bus of ram_burst_master: burst request, write-data stream,
// read-return stream and completion pulses.
interface ram_burst_master_if;
  import ram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  logic              done;
  logic              err;

  // Client side: issues requests and write data, consumes read data.
  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, done, err
  );

  // Burst engine side.
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, done, err
  );

endinterface

// File: rtl/ram_burst_master.sv
// Burst engine in front of a 64x8 registered-read RAM.
// `define RAM_BURST_MASTER_WRAP_EN makes addresses wrap 63->0; otherwise bursts stop at 63.
module ram_burst_master
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ram_burst_master_if.slave bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_out
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_req_ready;
  logic              r_wr_ready;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_err_pend;

  logic              w_in_write;
  logic              w_wr_beat;
  logic              w_last;
  logic              w_drop;

  always_comb begin
    w_in_write = (r_state == ST_WRITE);
    w_wr_beat  = w_in_write && bus.wr_valid;
`ifdef RAM_BURST_MASTER_WRAP_EN
    w_last = (r_cnt == '0);
    w_drop = 1'b0;
`else
    // Reaching the top address ends the burst; any remaining beats are dropped.
    w_last = (r_cnt == '0) || (r_addr == ADDR_MAX);
    w_drop = (r_cnt != '0) && (r_addr == ADDR_MAX);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_err_pend  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_err_pend <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_addr      <= bus.req_addr;
            r_cnt       <= bus.req_len;
            r_req_ready <= 1'b0;
            if (bus.req_write) begin
              r_state    <= ST_WRITE;
              r_wr_ready <= 1'b1;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (bus.wr_valid) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (w_last) begin
              r_state     <= ST_IDLE;
              r_wr_ready  <= 1'b0;
              r_req_ready <= 1'b1;
            end
          end
        end
        ST_READ: begin
          // Read data returns one cycle after issue, so the flags for this
          // beat are delayed to line up with mem_out.
          r_rd_valid <= 1'b1;
          r_addr     <= r_addr + 1'b1;
          r_cnt      <= r_cnt - 1'b1;
          if (w_last) begin
            r_rd_last  <= 1'b1;
            r_err_pend <= w_drop;
            r_state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_wr_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Write-side signals follow wr_valid in the same cycle, so they stay combinational.
  always_comb begin
    mem_addr = r_addr;
    mem_rw   = w_wr_beat;
    mem_data = w_in_write ? bus.wr_data : '0;
  end

  always_comb begin
    bus.req_ready = r_req_ready;
    bus.wr_ready  = r_wr_ready;
    bus.rd_valid  = r_rd_valid;
    bus.rd_last   = r_rd_last;
    bus.rd_data   = r_rd_valid ? mem_out : '0;
    bus.done      = (w_wr_beat && w_last) || (r_state == ST_DRAIN);
    bus.err       = (w_wr_beat && w_drop) || r_err_pend;
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master paired with a 64x8 registered-read RAM model;
// expectations adapt to RAM_BURST_MASTER_WRAP_EN.
module tb_ram_burst_master;

`ifdef RAM_BURST_MASTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_rw;
  logic [7:0] mem_out;
  logic       ram_clear;
  logic [7:0] ram    [64];
  logic [7:0] shadow [64];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  ram_burst_master_if bus();

  ram_burst_master u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_rw   (mem_rw),
    .mem_out  (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_byte(i);
    end else if (mem_rw) begin
      ram[mem_addr] <= mem_data;
    end
    mem_out <= ram[mem_addr];
  end

  function automatic logic [5:0] baddr(input logic [5:0] a, input int i);
    return 6'((int'(a) + i) % 64);
  endfunction

  // Beats actually performed: full length with wrap, else clipped at address 63.
  function automatic int model_beats(input logic [5:0] a, input logic [5:0] len);
    int n;
    n = int'(len) + 1;
    if (!WRAP && (int'(a) + n > 64)) n = 64 - int'(a);
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " mem_rw"},    32'(mem_rw),        32'd0);
    check({tag, " mem_data"},  32'(mem_data),      32'd0);
    check({tag, " wr_ready"},  32'(bus.wr_ready),  32'd0);
    check({tag, " rd_valid"},  32'(bus.rd_valid),  32'd0);
    check({tag, " done"},      32'(bus.done),      32'd0);
    check({tag, " err"},       32'(bus.err),       32'd0);
  endtask

  task automatic issue_req(input bit wr, input logic [5:0] a, input logic [5:0] len);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = len;
    #1;
    check("req_ready_at_req", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_write(input logic [5:0] a, input logic [5:0] len, input int unsigned gap,
                           input bit fixed, input int nb, input bit drop);
    logic [7:0] d [64];
    int k;
    int cyc;
    bit v;
    for (int i = 0; i < 64; i++) d[i] = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
    issue_req(1'b1, a, len);
    k = 0;
    cyc = 0;
    while (k < nb && cyc < 400) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.wr_valid = v;
      bus.wr_data  = v ? d[k] : 8'($urandom);
      #1;
      check("wr_ready", 32'(bus.wr_ready), 32'd1);
      check("wr_mem_rw", 32'(mem_rw), 32'(v));
      check("wr_req_ready", 32'(bus.req_ready), 32'd0);
      check("wr_done", 32'(bus.done), 32'(v && k == nb - 1));
      check("wr_err", 32'(bus.err), 32'(v && k == nb - 1 && drop));
      if (v) begin
        check("wr_mem_addr", 32'(mem_addr), 32'(baddr(a, k)));
        check("wr_mem_data", 32'(mem_data), 32'(d[k]));
        shadow[baddr(a, k)] = d[k];
        k++;
      end
      cyc++;
    end
    if (k < nb) check("wr_beat_timeout", 32'(k), 32'(nb));
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    check_idle("post_write");
    for (int i = 0; i <= int'(len); i++)
      check("ram_contents", 32'(ram[baddr(a, i)]), 32'(shadow[baddr(a, i)]));
  endtask

  task automatic run_read(input logic [5:0] a, input logic [5:0] len, input int nb, input bit drop);
    bit ev;
    issue_req(1'b0, a, len);
    for (int c = 0; c <= nb + 1; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      ev = (c >= 1) && (c <= nb);
      check("rd_mem_rw", 32'(mem_rw), 32'd0);
      if (c < nb) check("rd_mem_addr", 32'(mem_addr), 32'(baddr(a, c)));
      check("rd_valid", 32'(bus.rd_valid), 32'(ev));
      check("rd_last", 32'(bus.rd_last), 32'(ev && c == nb));
      check("rd_done", 32'(bus.done), 32'(c == nb));
      check("rd_err", 32'(bus.err), 32'(c == nb && drop));
      check("rd_req_ready", 32'(bus.req_ready), 32'(c == nb + 1));
      if (ev) check("rd_data", 32'(bus.rd_data), 32'(shadow[baddr(a, c - 1)]));
    end
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [5:0]  len;
    int unsigned gap;
    bit          fixed;
    int          exp_beats;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 6'd5,  6'd3,  0, 1'b1, 4, 1'b0};
    tbl[1] = '{1'b0, 6'd5,  6'd3,  0, 1'b0, 4, 1'b0};
    tbl[2] = '{1'b1, 6'd10, 6'd3,  1, 1'b0, 4, 1'b0};
    tbl[3] = '{1'b0, 6'd10, 6'd3,  0, 1'b0, 4, 1'b0};
    tbl[4] = '{1'b1, 6'd62, 6'd3,  0, 1'b0, WRAP ? 4 : 2, !WRAP};
    tbl[5] = '{1'b0, 6'd62, 6'd3,  0, 1'b0, WRAP ? 4 : 2, !WRAP};
    tbl[6] = '{1'b0, 6'd63, 6'd0,  0, 1'b0, 1, 1'b0};
    tbl[7] = '{1'b1, 6'd0,  6'd63, 2, 1'b0, 64, 1'b0};
    tbl[8] = '{1'b0, 6'd0,  6'd63, 0, 1'b0, 64, 1'b0};
    tbl[9] = '{1'b1, 6'd40, 6'd0,  1, 1'b0, 1, 1'b0};

    for (int i = 0; i < 64; i++) shadow[i] = init_byte(i);
    rst_n         = 1'b0;
    ram_clear     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset rd_last", 32'(bus.rd_last), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    ram_clear = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr)
        run_write(tbl[i].addr, tbl[i].len, tbl[i].gap, tbl[i].fixed, tbl[i].exp_beats, tbl[i].exp_err);
      else
        run_read(tbl[i].addr, tbl[i].len, tbl[i].exp_beats, tbl[i].exp_err);
    end

    // Reset during the third beat of a 4-beat write: only the first two land.
    begin
      logic [7:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      issue_req(1'b1, 6'd20, 6'd3);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = d[k];
        shadow[20 + k] = d[k];
      end
      @(negedge clk);
      bus.wr_data = d[2];
      rst_n = 1'b0;
      #1;
      check_idle("abort_write");
      check("abort_write mem_addr", 32'(mem_addr), 32'd0);
      check("abort_write rd_last", 32'(bus.rd_last), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.wr_valid = 1'b0;
      #1;
      check_idle("after_abort_write");
      for (int i = 0; i < 4; i++)
        check("abort_ram", 32'(ram[20 + i]), 32'(shadow[20 + i]));
    end

    // Reset while a read beat is pending: the beat is never delivered.
    issue_req(1'b0, 6'd0, 6'd5);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_read rd_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_read req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("after_abort_read");

    for (int n = 0; n < 40; n++) begin
      logic [5:0] a;
      logic [5:0] len;
      int nb;
      a   = 6'($urandom);
      len = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
      nb  = model_beats(a, len);
      if ($urandom_range(0, 1) == 1)
        run_write(a, len, $urandom_range(0, 2), 1'b0, nb, nb < int'(len) + 1);
      else
        run_read(a, len, nb, nb < int'(len) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
